a1_485_cmd_rx: RTL and testbench

Upstream RS-485 command receiver that feeds the A1 transceiver direction controller.
- Deserialises the A1 RS-485 line (8N1, LSB first).
- Parses fixed 4-byte command frames: HEAD0, HEAD1, CMD, SUM.
- On a valid frame, presents the command byte on CMD and pulses Receive_finish. The direction controller consumes these and turns the transceiver around to transmit.
- Only listens while the transceiver is in receive mode.

---
 rtl/a1_485_pkg.sv | 30 +++
 rtl/a1_485_uart_rx.sv | 98 +++++++++
 rtl/a1_485_cmd_rx.sv | 118 +++++++++++
 tb/tb_a1_485_cmd_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/a1_485_pkg.sv
// Shared constants, state encodings and checksum helper for the A1 RS-485 command path.
package a1_485_pkg;

    localparam int         CLK_DIV_DEF = 833;      // 96 MHz / 115200 baud
    localparam int         BYTE_TO_DEF = 16660;    // ~20 bit times
    localparam logic [7:0] HEAD0_DEF   = 8'hEB;
    localparam logic [7:0] HEAD1_DEF   = 8'h90;
    localparam logic [7:0] CMD_RESPOND = 8'h2E;

    typedef enum logic [1:0] {
        P_HEAD0 = 2'd0,
        P_HEAD1 = 2'd1,
        P_CMD   = 2'd2,
        P_SUM   = 2'd3
    } pstate_t;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_START = 2'd1,
        B_DATA  = 2'd2,
        B_STOP  = 2'd3
    } bstate_t;

    // 8-bit sum, carry discarded.
    function automatic logic [7:0] frame_sum(input logic [7:0] h0, input logic [7:0] h1,
                                             input logic [7:0] cmd);
        return h0 + h1 + cmd;
    endfunction

endpackage

// File: rtl/a1_485_uart_rx.sv
// 8N1 LSB-first deserialiser with 2-FF input synchroniser and abort.
// state   | meaning
// B_IDLE  | waiting for a falling edge on rxs
// B_START | half-bit wait, confirm start bit is still low
// B_DATA  | eight full-bit samples shifted in LSB first
// B_STOP  | full-bit wait, check stop bit
module a1_485_uart_rx
    import a1_485_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic       clk_96M,
    input  logic       rst,
    input  logic       rx,
    input  logic       abort,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       stop_err
);

    localparam int            CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LD = CW'(CLK_DIV - 1);

    logic          sync1_q, rxs_q, rxs_prev_q;
    bstate_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_fall, tc;

    always_ff @(posedge clk_96M or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= B_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            sync1_q    <= rx;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    assign rx_fall = rxs_prev_q & ~rxs_q;
    assign tc      = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = tc ? cnt_q : cnt_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            B_IDLE: begin
                if (rx_fall) begin
                    state_d = B_START;
                    cnt_d   = HALF_LD;
                end
            end
            B_START: begin
                if (tc) begin
                    state_d = rxs_q ? B_IDLE : B_DATA;
                    cnt_d   = rxs_q ? '0 : FULL_LD;
                    bit_d   = '0;
                end
            end
            B_DATA: begin
                if (tc) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = FULL_LD;
                    if (bit_q == 3'd7) state_d = B_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            B_STOP: begin
                if (tc) state_d = B_IDLE;
            end
        endcase
        if (abort) begin
            state_d = B_IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        rx_byte    = shift_q;
        byte_valid = (state_q == B_STOP) && tc && rxs_q  && !abort;
        stop_err   = (state_q == B_STOP) && tc && !rxs_q && !abort;
    end

endmodule

// File: rtl/a1_485_cmd_rx.sv
// A1 RS-485 command receiver: frames HEAD0 HEAD1 CMD SUM into a command byte.
// state   | meaning
// P_HEAD0 | idle, hunting for HEAD0
// P_HEAD1 | HEAD0 seen, expecting HEAD1 (HEAD0 again resyncs)
// P_CMD   | next byte is the command
// P_SUM   | next byte is the checksum
module a1_485_cmd_rx
    import a1_485_pkg::*;
#(
    parameter int         CLK_DIV = CLK_DIV_DEF,
    parameter int         BYTE_TO = BYTE_TO_DEF,
    parameter logic [7:0] HEAD0   = HEAD0_DEF,
    parameter logic [7:0] HEAD1   = HEAD1_DEF
) (
    input  logic       clk_96M,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_block,
    output logic [7:0] CMD,
    output logic       Receive_finish,
    output logic       frame_err,
    output logic       busy
);

    localparam int            TW    = $clog2(BYTE_TO + 1);
    // Loaded so the registered frame_err lands BYTE_TO cycles after byte_valid.
    localparam logic [TW-1:0] TO_LD = TW'(BYTE_TO - 2);

    logic [7:0]    rx_byte;
    logic          byte_valid, stop_err, timeout;
    pstate_t       pstate_q, pstate_d;
    logic [7:0]    cmd_tmp_q, cmd_tmp_d, cmd_q, cmd_d;
    logic          rf_q, rf_d, fe_q, fe_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    a1_485_uart_rx #(.CLK_DIV(CLK_DIV)) u_uart_rx (
        .clk_96M    (clk_96M),
        .rst        (rst),
        .rx         (rx),
        .abort      (rx_block),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .stop_err   (stop_err)
    );

    always_ff @(posedge clk_96M or posedge rst) begin
        if (rst) begin
            pstate_q  <= P_HEAD0;
            cmd_tmp_q <= '0;
            cmd_q     <= '0;
            rf_q      <= 1'b0;
            fe_q      <= 1'b0;
            to_cnt_q  <= TO_LD;
        end else begin
            pstate_q  <= pstate_d;
            cmd_tmp_q <= cmd_tmp_d;
            cmd_q     <= cmd_d;
            rf_q      <= rf_d;
            fe_q      <= fe_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign timeout = (pstate_q != P_HEAD0) && (to_cnt_q == '0);

    always_comb begin
        pstate_d  = pstate_q;
        cmd_tmp_d = cmd_tmp_q;
        cmd_d     = cmd_q;
        rf_d      = 1'b0;
        fe_d      = 1'b0;
        to_cnt_d  = to_cnt_q;
        if (rx_block) begin
            pstate_d = P_HEAD0;
            to_cnt_d = TO_LD;
        end else if (byte_valid) begin
            to_cnt_d = TO_LD;
            case (pstate_q)
                P_HEAD0: if (rx_byte == HEAD0) pstate_d = P_HEAD1;
                P_HEAD1: begin
                    if (rx_byte == HEAD1)      pstate_d = P_CMD;
                    else if (rx_byte != HEAD0) pstate_d = P_HEAD0;
                end
                P_CMD: begin
                    cmd_tmp_d = rx_byte;
                    pstate_d  = P_SUM;
                end
                P_SUM: begin
                    if (rx_byte == frame_sum(HEAD0, HEAD1, cmd_tmp_q)) begin
                        cmd_d = cmd_tmp_q;
                        rf_d  = 1'b1;
                    end else begin
                        fe_d  = 1'b1;
                    end
                    pstate_d = P_HEAD0;
                end
            endcase
        end else if (stop_err) begin
            fe_d     = (pstate_q != P_HEAD0);
            pstate_d = P_HEAD0;
            to_cnt_d = TO_LD;
        end else if (timeout) begin
            fe_d     = 1'b1;
            pstate_d = P_HEAD0;
            to_cnt_d = TO_LD;
        end else if (pstate_q != P_HEAD0) begin
            to_cnt_d = to_cnt_q - 1'b1;
        end
    end

    always_comb begin
        CMD            = cmd_q;
        Receive_finish = rf_q;
        frame_err      = fe_q;
        busy           = (pstate_q != P_HEAD0);
    end

endmodule

// File: tb/tb_a1_485_cmd_rx.sv
// Directed bench for a1_485_cmd_rx, run with a short bit period and timeout.
module tb_a1_485_cmd_rx;
    import a1_485_pkg::*;

    localparam int D    = 16;
    localparam int HALF = D / 2;
    localparam int TO   = 320;
    // Start edge to Receive_finish: 2 sync flops + edge flop, half bit, nine bits.
    localparam int LAT  = 3 + HALF + 9 * D;

    logic       clk_96M = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_block = 1'b0;
    logic [7:0] CMD;
    logic       Receive_finish, frame_err, busy;

    int cyc = 0, n_chk = 0, n_err = 0;
    int rf_cnt = 0, fe_cnt = 0, both_cnt = 0, rf_cyc = 0, fe_cyc = 0;
    logic busy_at_rf = 1'b0, busy_pre_rf = 1'b0, prev_busy = 1'b0;
    int n_last, n_dummy, rf0, fe0;

    a1_485_cmd_rx #(.CLK_DIV(D), .BYTE_TO(TO)) dut (
        .clk_96M        (clk_96M),
        .rst            (rst),
        .rx             (rx),
        .rx_block       (rx_block),
        .CMD            (CMD),
        .Receive_finish (Receive_finish),
        .frame_err      (frame_err),
        .busy           (busy)
    );

    always #5 clk_96M = ~clk_96M;
    always @(posedge clk_96M) cyc <= cyc + 1;

    always @(negedge clk_96M) begin
        if (Receive_finish) begin
            rf_cnt++;
            rf_cyc      = cyc;
            busy_at_rf  = busy;
            busy_pre_rf = prev_busy;
        end
        if (frame_err) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (Receive_finish && frame_err) both_cnt++;
        prev_busy = busy;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int n_start);
        @(posedge clk_96M); #1;
        n_start = cyc;
        rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (D) @(posedge clk_96M); #1;
            rx = b[i];
        end
        repeat (D) @(posedge clk_96M); #1;
        rx = stop_bit;
        repeat (D) @(posedge clk_96M); #1;
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] s, output int n_sum);
        int n;
        send_byte(8'hEB, 1'b1, n);
        send_byte(8'h90, 1'b1, n);
        send_byte(c, 1'b1, n);
        send_byte(s, 1'b1, n_sum);
    endtask

    task automatic mark;
        repeat (20) @(posedge clk_96M); #1;
        rf0 = rf_cnt;
        fe0 = fe_cnt;
    endtask

    task automatic settle;
        repeat (20) @(posedge clk_96M); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk_96M); #1;
        check_eq("rst_cmd", CMD, 8'h00);
        check_eq("rst_rf", Receive_finish, 0);
        check_eq("rst_fe", frame_err, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;

        // 1: good frame
        mark();
        send_frame(CMD_RESPOND, 8'hA9, n_last);
        settle();
        check_eq("t1_rf_cnt", rf_cnt - rf0, 1);
        check_eq("t1_fe_cnt", fe_cnt - fe0, 0);
        check_eq("t1_cmd", CMD, 8'h2E);
        check_eq("t1_latency", rf_cyc - n_last, LAT);
        check_eq("t1_busy_at_rf", busy_at_rf, 0);
        check_eq("t1_busy_before_rf", busy_pre_rf, 1);

        // 2: bad checksum
        mark();
        send_frame(8'h11, 8'h8D, n_last);
        settle();
        check_eq("t2_fe_cnt", fe_cnt - fe0, 1);
        check_eq("t2_rf_cnt", rf_cnt - rf0, 0);
        check_eq("t2_cmd", CMD, 8'h2E);
        check_eq("t2_busy", busy, 0);

        // 3: duplicated head resync
        mark();
        send_byte(8'hEB, 1'b1, n_dummy);
        send_frame(8'h11, 8'h8C, n_last);
        settle();
        check_eq("t3_rf_cnt", rf_cnt - rf0, 1);
        check_eq("t3_fe_cnt", fe_cnt - fe0, 0);
        check_eq("t3_cmd", CMD, 8'h11);

        // 4: inter-byte timeout, then recovery
        mark();
        send_byte(8'hEB, 1'b1, n_dummy);
        send_byte(8'h90, 1'b1, n_last);
        check_eq("t4_busy_waiting", busy, 1);
        repeat (TO + 50) @(posedge clk_96M); #1;
        check_eq("t4_fe_cnt", fe_cnt - fe0, 1);
        check_eq("t4_fe_time", fe_cyc, n_last + (LAT - 1) + TO);
        check_eq("t4_busy_after", busy, 0);
        send_frame(8'h2E, 8'hA9, n_last);
        settle();
        check_eq("t4_rf_cnt", rf_cnt - rf0, 1);
        check_eq("t4_cmd", CMD, 8'h2E);

        // 5a: bad stop bit on SUM, then bad stop bit while hunting
        mark();
        send_byte(8'hEB, 1'b1, n_dummy);
        send_byte(8'h90, 1'b1, n_dummy);
        send_byte(8'h11, 1'b1, n_dummy);
        send_byte(8'h8C, 1'b0, n_last);
        settle();
        check_eq("t5a_fe_cnt", fe_cnt - fe0, 1);
        check_eq("t5a_rf_cnt", rf_cnt - rf0, 0);
        check_eq("t5a_cmd", CMD, 8'h2E);
        mark();
        send_byte(8'h55, 1'b0, n_dummy);
        settle();
        check_eq("t5a_head0_stop_err", fe_cnt - fe0, 0);

        // 5b: rx_block mid-CMD byte discards the partial frame
        mark();
        send_byte(8'hEB, 1'b1, n_dummy);
        send_byte(8'h90, 1'b1, n_dummy);
        @(posedge clk_96M); #1;
        rx = 1'b0;
        repeat (4 * D) @(posedge clk_96M); #1;
        rx_block = 1'b1;
        rx = 1'b1;
        repeat (500) @(posedge clk_96M); #1;
        check_eq("t5b_busy_blocked", busy, 0);
        repeat (500) @(posedge clk_96M); #1;
        rx_block = 1'b0;
        settle();
        send_frame(8'h11, 8'h8C, n_last);
        settle();
        check_eq("t5b_rf_cnt", rf_cnt - rf0, 1);
        check_eq("t5b_fe_cnt", fe_cnt - fe0, 0);
        check_eq("t5b_cmd", CMD, 8'h11);

        // 6: async reset mid-DATA of CMD byte
        send_byte(8'hEB, 1'b1, n_dummy);
        send_byte(8'h90, 1'b1, n_dummy);
        @(posedge clk_96M); #1;
        rx = 1'b0;
        repeat (4 * D) @(posedge clk_96M); #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_cmd", CMD, 8'h00);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_rf", Receive_finish, 0);
        check_eq("t6_rst_fe", frame_err, 0);
        rx = 1'b1;
        @(posedge clk_96M); #1;
        rst = 1'b0;
        mark();
        send_frame(8'h2E, 8'hA9, n_last);
        settle();
        check_eq("t6_rf_cnt", rf_cnt - rf0, 1);
        check_eq("t6_cmd", CMD, 8'h2E);

        // 6b: short low glitch between HEAD0 and HEAD1 must not form a byte
        mark();
        send_byte(8'hEB, 1'b1, n_dummy);
        @(posedge clk_96M); #1;
        rx = 1'b0;
        repeat (5) @(posedge clk_96M); #1;
        rx = 1'b1;
        repeat (40) @(posedge clk_96M); #1;
        send_byte(8'h90, 1'b1, n_dummy);
        send_byte(8'h11, 1'b1, n_dummy);
        send_byte(8'h8C, 1'b1, n_last);
        settle();
        check_eq("t6b_rf_cnt", rf_cnt - rf0, 1);
        check_eq("t6b_fe_cnt", fe_cnt - fe0, 0);
        check_eq("t6b_cmd", CMD, 8'h11);

        check_eq("rf_fe_exclusive", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
